axis_spi_slave_os: RTL and testbench

AXIS_SPI_SLAVE_OS -- requirements
Module: axis_spi_slave_os

---
 rtl/spi_pkg.sv | 14 +
 rtl/axis_if.sv | 8 +
 rtl/sync_fifo.sv | 37 +++
 rtl/axis_spi_slave_os.sv | 138 +++++++++++++
 tb/tb_axis_spi_slave_os.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode constants, CPOL/CPHA decode helpers and frame FSM states.
package spi_pkg;
   localparam logic [1:0] SPI_MODE0 = 2'd0;
   localparam logic [1:0] SPI_MODE1 = 2'd1;
   localparam logic [1:0] SPI_MODE2 = 2'd2;
   localparam logic [1:0] SPI_MODE3 = 2'd3;
   typedef enum logic {IDLE, FRAME} frame_state_t;
   function automatic logic spi_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction
   function automatic logic spi_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction
endpackage

// File: rtl/axis_if.sv
// axis_if: minimal AXI-Stream channel (data, valid, ready).
interface axis_if #(parameter int DW = 8);
   logic [DW-1:0] tdata;
   logic tvalid;
   logic tready;
   modport master(output tdata, output tvalid, input tready);
   modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push on a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic spi_clk,
   input logic arstn_i,
   input logic push,
   input logic [WIDTH-1:0] din,
   input logic pop,
   output logic [WIDTH-1:0] dout,
   output logic [$clog2(DEPTH):0] level,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr, rd;
   assign rd = pop && !empty;
   assign wr = push && (!full || rd);
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign dout = mem[rp];
   always_ff @(posedge spi_clk or negedge arstn_i)
      if (!arstn_i) begin
         wp <= '0;
         rp <= '0;
         level <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         level <= level + (AW+1)'(wr) - (AW+1)'(rd);
      end
   always_ff @(posedge spi_clk)
      if (wr) mem[wp] <= din;
endmodule

// File: rtl/axis_spi_slave_os.sv
// axis_spi_slave_os: oversampling SPI slave bridging SPI frames to AXI-Stream TX/RX FIFOs.
// SPI pins are synchronised into spi_clk and sck is edge-detected, never used as a clock.
module axis_spi_slave_os
   import spi_pkg::*;
#(
   parameter int SPI_MODE = 0,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST = 1'b1,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD = '0
) (
   input logic spi_clk,
   input logic arstn_i,
   input logic spi_sck_i,
   input logic spi_cs_n_i,
   input logic spi_mosi_i,
   output logic spi_miso_o,
   output logic spi_miso_oe_o,
   axis_if.slave s_axis,
   axis_if.master m_axis,
   input logic clr_i,
   output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
   output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
   output logic tx_underrun_o,
   output logic rx_overrun_o,
   output logic busy_o
);
   localparam logic CPOL = spi_cpol(2'(SPI_MODE));
   localparam logic CPHA = spi_cpha(2'(SPI_MODE));
   localparam int CW = $clog2(DATA_WIDTH);
   logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q, vld_q;
   logic sck_s, cs_s, mosi_s, sck_d, cs_d, armed;
   logic lead, trail, sample_edge, shift_edge, cs_fall;
   frame_state_t state, state_n;
   logic load, smp, shf, done, from_fifo, tx_pop, rx_pop;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic [CW-1:0] bit_cnt;
   logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, tx_head;
   // armed needs a genuinely sampled CS high, so a frame live at reset release is ignored
   always_ff @(posedge spi_clk or negedge arstn_i)
      if (!arstn_i) begin
         sck_q <= {SYNC_STAGES{CPOL}};
         cs_q <= '1;
         mosi_q <= '0;
         vld_q <= '0;
         sck_d <= CPOL;
         cs_d <= 1'b1;
         armed <= 1'b0;
      end else begin
         sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck_i};
         cs_q <= {cs_q[SYNC_STAGES-2:0], spi_cs_n_i};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
         vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         sck_d <= sck_s;
         cs_d <= cs_s;
         armed <= armed || (vld_q[SYNC_STAGES-1] && cs_s);
      end
   assign sck_s = sck_q[SYNC_STAGES-1];
   assign cs_s = cs_q[SYNC_STAGES-1];
   assign mosi_s = mosi_q[SYNC_STAGES-1];
   assign lead = sck_d == CPOL && sck_s != CPOL;
   assign trail = sck_d != CPOL && sck_s == CPOL;
   assign sample_edge = CPHA ? trail : lead;
   assign shift_edge = CPHA ? lead : trail;
   assign cs_fall = armed && cs_d && !cs_s;
   assign rx_next = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_shift[DATA_WIDTH-1:1]};
   always_comb begin
      state_n = state;
      load = 1'b0;
      smp = 1'b0;
      shf = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: begin
            state_n = cs_fall ? FRAME : IDLE;
            load = cs_fall;
         end
         FRAME: begin
            state_n = cs_s ? IDLE : FRAME;
            smp = !cs_s && sample_edge;
            shf = !cs_s && shift_edge && bit_cnt != '0;
            done = smp && bit_cnt == CW'(DATA_WIDTH - 1);
            load = done;
         end
      endcase
   end
   assign tx_pop = smp && bit_cnt == '0 && from_fifo;
   assign rx_pop = m_axis.tvalid && m_axis.tready;
   always_ff @(posedge spi_clk or negedge arstn_i)
      if (!arstn_i) begin
         state <= IDLE;
         bit_cnt <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         from_fifo <= 1'b0;
         tx_underrun_o <= 1'b0;
         rx_overrun_o <= 1'b0;
      end else begin
         state <= state_n;
         if (load || state_n == IDLE) bit_cnt <= '0;
         else if (smp) bit_cnt <= bit_cnt + CW'(1);
         if (load) begin
            tx_shift <= tx_empty ? FILL_WORD : tx_head;
            from_fifo <= !tx_empty;
         end else if (shf) tx_shift <= MSB_FIRST ? tx_shift << 1 : tx_shift >> 1;
         if (smp) rx_shift <= rx_next;
         tx_underrun_o <= (load && tx_empty) || (tx_underrun_o && !clr_i);
         rx_overrun_o <= (done && rx_full && !rx_pop) || (rx_overrun_o && !clr_i);
      end
   assign busy_o = state == FRAME;
   assign spi_miso_oe_o = state == FRAME;
   assign spi_miso_o = state == FRAME && (MSB_FIRST ? tx_shift[DATA_WIDTH-1] : tx_shift[0]);
   assign s_axis.tready = arstn_i && !tx_full;
   assign m_axis.tvalid = !rx_empty;
   sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .spi_clk,
      .arstn_i,
      .push(s_axis.tvalid && s_axis.tready),
      .din(s_axis.tdata),
      .pop(tx_pop),
      .dout(tx_head),
      .level(tx_level_o),
      .full(tx_full),
      .empty(tx_empty)
   );
   sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .spi_clk,
      .arstn_i,
      .push(done),
      .din(rx_next),
      .pop(rx_pop),
      .dout(m_axis.tdata),
      .level(rx_level_o),
      .full(rx_full),
      .empty(rx_empty)
   );
endmodule

// File: tb/tb_axis_spi_slave_os.sv
// tb_axis_spi_slave_os: one slave per SPI mode (depth 4, fill 0xEE) driven by a bit-banged master,
// checked against word-level TX/RX queues of what the master should see.
module tb_axis_spi_slave_os;
   localparam int H = 80;
   localparam logic [7:0] FILL = 8'hEE;
   logic clk = 1'b0;
   logic arstn = 1'b0;
   logic sck [4], cs_n [4], mosi [4], miso [4], oe [4], busy [4], clr [4], unf [4], ovr [4];
   logic [2:0] tx_lvl [4], rx_lvl [4];
   logic [7:0] tx_data [4], rx_data [4];
   logic tx_valid [4], tx_ready [4], rx_valid [4], rx_ready [4];
   logic [7:0] txq [4][$];
   logic [7:0] rxq [4][$];
   logic [7:0] mo_fix [$];
   logic m_unf [4], m_ovr [4];
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : u
      axis_if #(.DW(8)) txi ();
      axis_if #(.DW(8)) rxi ();
      assign txi.tdata = tx_data[g];
      assign txi.tvalid = tx_valid[g];
      assign tx_ready[g] = txi.tready;
      assign rxi.tready = rx_ready[g];
      assign rx_valid[g] = rxi.tvalid;
      assign rx_data[g] = rxi.tdata;
      axis_spi_slave_os #(
         .SPI_MODE(g), .DATA_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .MSB_FIRST(1'b1), .FILL_WORD(FILL)
      ) dut (
         .spi_clk(clk),
         .arstn_i(arstn),
         .spi_sck_i(sck[g]),
         .spi_cs_n_i(cs_n[g]),
         .spi_mosi_i(mosi[g]),
         .spi_miso_o(miso[g]),
         .spi_miso_oe_o(oe[g]),
         .s_axis(txi),
         .m_axis(rxi),
         .clr_i(clr[g]),
         .tx_level_o(tx_lvl[g]),
         .rx_level_o(rx_lvl[g]),
         .tx_underrun_o(unf[g]),
         .rx_overrun_o(ovr[g]),
         .busy_o(busy[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_reset();
      for (int m = 0; m < 4; m++) begin
         check($sformatf("m%0d rst tready", m), tx_ready[m], 0);
         check($sformatf("m%0d rst tvalid", m), rx_valid[m], 0);
         check($sformatf("m%0d rst tx_level", m), tx_lvl[m], 0);
         check($sformatf("m%0d rst rx_level", m), rx_lvl[m], 0);
         check($sformatf("m%0d rst underrun", m), unf[m], 0);
         check($sformatf("m%0d rst overrun", m), ovr[m], 0);
         check($sformatf("m%0d rst busy", m), busy[m], 0);
         check($sformatf("m%0d rst miso", m), miso[m], 0);
         check($sformatf("m%0d rst miso_oe", m), oe[m], 0);
      end
   endtask
   task automatic model_reset();
      for (int m = 0; m < 4; m++) begin
         txq[m].delete();
         rxq[m].delete();
         m_unf[m] = 1'b0;
         m_ovr[m] = 1'b0;
      end
   endtask
   task automatic check_state(input int m);
      check($sformatf("m%0d tx_level", m), tx_lvl[m], txq[m].size());
      check($sformatf("m%0d rx_level", m), rx_lvl[m], rxq[m].size());
      check($sformatf("m%0d underrun", m), unf[m], m_unf[m]);
      check($sformatf("m%0d overrun", m), ovr[m], m_ovr[m]);
      check($sformatf("m%0d tready", m), tx_ready[m], txq[m].size() < 4);
      check($sformatf("m%0d tvalid", m), rx_valid[m], rxq[m].size() != 0);
      check($sformatf("m%0d idle busy", m), busy[m], 0);
      check($sformatf("m%0d idle miso_oe", m), oe[m], 0);
      check($sformatf("m%0d idle miso", m), miso[m], 0);
   endtask
   task automatic push_tx(input int m, input logic [7:0] v);
      @(negedge clk);
      tx_data[m] = v;
      tx_valid[m] = 1'b1;
      check($sformatf("m%0d push tready", m), tx_ready[m], 1);
      @(negedge clk);
      tx_valid[m] = 1'b0;
      txq[m].push_back(v);
   endtask
   task automatic clear_flags(input int m);
      @(negedge clk);
      clr[m] = 1'b1;
      @(negedge clk);
      clr[m] = 1'b0;
      m_unf[m] = 1'b0;
      m_ovr[m] = 1'b0;
   endtask
   task automatic drain(input int m);
      @(negedge clk);
      rx_ready[m] = 1'b1;
      while (rxq[m].size() != 0) begin
         check($sformatf("m%0d rx tvalid", m), rx_valid[m], 1);
         check($sformatf("m%0d rx tdata", m), rx_data[m], rxq[m].pop_front());
         @(negedge clk);
      end
      rx_ready[m] = 1'b0;
      check($sformatf("m%0d drained tvalid", m), rx_valid[m], 0);
   endtask
   // master side: drives MOSI MSB first and returns what it sampled on MISO
   task automatic spi_bits(input int m, input logic [7:0] w, input int nb, output logic [7:0] got);
      logic [1:0] md;
      md = 2'(m);
      got = '0;
      for (int i = 0; i < nb; i++) begin
         if (!md[0]) mosi[m] = w[7-i];
         #H;
         sck[m] = !md[1];
         if (md[0]) mosi[m] = w[7-i];
         else got[7-i] = miso[m];
         #H;
         sck[m] = md[1];
         if (md[0]) got[7-i] = miso[m];
      end
   endtask
   // k full words then an optional partial word of part bits; every word start loads the TX head
   task automatic spi_frame(input int m, input int k, input int part);
      logic [7:0] exp, mo, got;
      logic from_q;
      int nb;
      @(negedge clk);
      cs_n[m] = 1'b0;
      #H;
      check($sformatf("m%0d frame busy", m), busy[m], 1);
      check($sformatf("m%0d frame miso_oe", m), oe[m], 1);
      for (int w = 0; w <= k; w++) begin
         nb = (w < k) ? 8 : part;
         from_q = txq[m].size() != 0;
         if (from_q) exp = txq[m][0];
         else begin
            exp = FILL;
            m_unf[m] = 1'b1;
         end
         if (nb == 0) break;
         if (from_q) void'(txq[m].pop_front());
         if (mo_fix.size() != 0) mo = mo_fix.pop_front();
         else mo = 8'($urandom);
         spi_bits(m, mo, nb, got);
         if (nb == 8) begin
            check($sformatf("m%0d miso word %0d", m, w), got, exp);
            if (rxq[m].size() < 4) rxq[m].push_back(mo);
            else m_ovr[m] = 1'b1;
         end
      end
      #H;
      cs_n[m] = 1'b1;
      #(2*H);
   endtask
   initial begin
      logic [7:0] got;
      for (int m = 0; m < 4; m++) begin
         sck[m] = m[1];
         cs_n[m] = 1'b1;
         mosi[m] = 1'b0;
         clr[m] = 1'b0;
         tx_valid[m] = 1'b0;
         tx_data[m] = '0;
         rx_ready[m] = 1'b0;
      end
      model_reset();
      #33;
      check_reset();
      @(negedge clk);
      arstn = 1'b1;
      repeat (4) @(negedge clk);
      push_tx(0, 8'hA5);
      check_state(0);
      mo_fix.push_back(8'h3C);
      spi_frame(0, 1, 0);
      check_state(0);
      drain(0);
      clear_flags(0);
      check_state(0);
      for (int m = 1; m < 4; m++) begin
         push_tx(m, 8'h01);
         push_tx(m, 8'h80);
         push_tx(m, 8'hFF);
         spi_frame(m, 3, 0);
         check_state(m);
         drain(m);
         clear_flags(m);
      end
      spi_frame(2, 1, 0);
      check_state(2);
      clear_flags(2);
      check_state(2);
      drain(2);
      push_tx(0, 8'($urandom));
      push_tx(0, 8'($urandom));
      spi_frame(0, 5, 0);
      check_state(0);
      drain(0);
      clear_flags(0);
      check_state(0);
      push_tx(3, 8'($urandom));
      push_tx(3, 8'($urandom));
      spi_frame(3, 0, 3);
      check_state(3);
      spi_frame(3, 1, 0);
      check_state(3);
      drain(3);
      clear_flags(3);
      for (int it = 0; it < 16; it++) begin
         int m, np;
         m = $urandom_range(3, 0);
         np = $urandom_range(4 - txq[m].size(), 0);
         repeat (np) push_tx(m, 8'($urandom));
         spi_frame(m, $urandom_range(3, 1), $urandom_range(1, 0) ? 0 : $urandom_range(7, 1));
         check_state(m);
         if ($urandom_range(1, 0) == 1) drain(m);
         if ($urandom_range(1, 0) == 1) clear_flags(m);
      end
      for (int m = 0; m < 4; m++) drain(m);
      push_tx(0, 8'($urandom));
      @(negedge clk);
      cs_n[0] = 1'b0;
      #H;
      spi_bits(0, 8'hC3, 3, got);
      check("m0 busy before reset", busy[0], 1);
      arstn = 1'b0;
      #2;
      check_reset();
      model_reset();
      #20;
      @(negedge clk);
      arstn = 1'b1;
      spi_bits(0, 8'($urandom), 8, got);
      check("m0 stale frame busy", busy[0], 0);
      check("m0 stale frame rx_level", rx_lvl[0], 0);
      cs_n[0] = 1'b1;
      #(2*H);
      push_tx(0, 8'($urandom));
      spi_frame(0, 1, 0);
      check_state(0);
      drain(0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
